// File: rtl/frequency_analyzer_defs.sv
// Shared register map and AXI response encodings for the frequency analyzer
// manager and the blocks that read its result bank.
package frequency_analyzer_defs;
  localparam int FREQ_FIRST_REG = 1;
  localparam int FREQ_REG_COUNT = 9;
  localparam int CFG_FIRST_REG  = 10;
  localparam int CFG_LAST_REG   = 17;
  localparam int REG_STRIDE     = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_PUSH, ST_CLEAR, ST_WAIT_LOW
  } frame_state_e;

  typedef enum logic [1:0] {CH_IDLE, CH_AR, CH_R} chan_phase_e;
endpackage

// File: rtl/axi_lite_read_channel.sv
// Single AXI4-Lite read: AR then R, with a cycle budget covering both phases.
// done/data/err are presented combinationally in the cycle the read resolves.
module axi_lite_read_channel
  import frequency_analyzer_defs::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  chan_phase_e       phase_q, phase_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tmo_hit;

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign rready  = rready_q;
  // >= rather than == so an AR accepted on the last budget cycle still expires in R
  assign tmo_hit = (phase_q != CH_IDLE) && (tmo_q >= TW'(TIMEOUT - 1));

  always_comb begin
    phase_d   = phase_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    tmo_d     = tmo_q;
    done      = 1'b0;
    data      = '0;
    err       = 1'b0;
    case (phase_q)
      CH_IDLE: if (start) begin
        phase_d   = CH_AR;
        arvalid_d = 1'b1;
        araddr_d  = addr;
        tmo_d     = '0;
      end
      CH_AR: begin
        if (arvalid_q && arready) begin
          phase_d   = CH_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = tmo_q + TW'(1);
        end else if (tmo_hit) begin
          phase_d   = CH_IDLE;
          arvalid_d = 1'b0;
          done      = 1'b1;
          err       = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CH_R: begin
        if (rready_q && rvalid) begin
          phase_d  = CH_IDLE;
          rready_d = 1'b0;
          done     = 1'b1;
          data     = rdata;
          err      = (rresp != RESP_OKAY);
        end else if (tmo_hit) begin
          phase_d  = CH_IDLE;
          rready_d = 1'b0;
          done     = 1'b1;
          err      = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: phase_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= CH_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      tmo_q     <= tmo_d;
    end
  end
endmodule

// File: rtl/frequency_report_reader.sv
// On each irq rising edge, reads the manager's frequency registers over AXI4-Lite,
// streams them out, then pulses analyzer_clear to re-arm the analyzers.
module frequency_report_reader
  import frequency_analyzer_defs::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 10,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int BASE_ADDRESS         = 0,
  parameter int FIRST_REGISTER       = 1,
  parameter int REGISTERS_NUMBER     = 9,
  parameter int READ_TIMEOUT_CYCLES  = 256
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            irq,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] result_data,
  output logic [3:0]                      result_index,
  output logic                            result_error,
  output logic                            result_last,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            analyzer_clear,
  output logic                            busy,
  output logic [15:0]                     frame_count,
  output logic [7:0]                      overrun_count
);
  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam logic [3:0] FIRST_IDX = 4'(FIRST_REGISTER);
  localparam logic [3:0] LAST_IDX  = 4'(FIRST_REGISTER + REGISTERS_NUMBER - 1);

  frame_state_e  state_q, state_d;
  logic          irq_q, start_evt;
  logic [3:0]    idx_q, idx_d;
  logic          busy_q, busy_d, valid_q, valid_d, clear_q, clear_d;
  logic          err_q, err_d, last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    rindex_q, rindex_d;
  logic [15:0]   frame_q, frame_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          ch_start, ch_done, ch_err;
  logic [AW-1:0] ch_addr;
  logic [DW-1:0] ch_data;

  assign start_evt      = irq & ~irq_q;
  assign m00_axi_arprot = 3'b000;
  assign result_data    = data_q;
  assign result_index   = rindex_q;
  assign result_error   = err_q;
  assign result_last    = last_q;
  assign result_valid   = valid_q;
  assign analyzer_clear = clear_q;
  assign busy           = busy_q;
  assign frame_count    = frame_q;
  assign overrun_count  = ovr_q;

  axi_lite_read_channel #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(READ_TIMEOUT_CYCLES)) u_rd (
    .clk(m00_axi_aclk), .rst_n(m00_axi_aresetn),
    .start(ch_start), .addr(ch_addr),
    .done(ch_done), .data(ch_data), .err(ch_err),
    .arvalid(m00_axi_arvalid), .araddr(m00_axi_araddr), .arready(m00_axi_arready),
    .rdata(m00_axi_rdata), .rresp(m00_axi_rresp), .rvalid(m00_axi_rvalid),
    .rready(m00_axi_rready)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    clear_d  = 1'b0;
    data_d   = data_q;
    rindex_d = rindex_q;
    err_d    = err_q;
    last_d   = last_q;
    frame_d  = frame_q;
    ovr_d    = ovr_q;
    ch_start = 1'b0;
    if (start_evt && state_q != ST_IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    case (state_q)
      ST_IDLE: if (start_evt) begin
        idx_d    = FIRST_IDX;
        busy_d   = 1'b1;
        ch_start = 1'b1;
        state_d  = ST_ADDR;
      end
      ST_ADDR: begin
        if (ch_done) state_d = ST_PUSH;
        else if (m00_axi_arvalid && m00_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: if (ch_done) state_d = ST_PUSH;
      ST_PUSH: if (result_ready) begin
        valid_d = 1'b0;
        if (last_q) begin
          clear_d = 1'b1;
          frame_d = frame_q + 16'd1;
          state_d = ST_CLEAR;
        end else begin
          idx_d    = idx_q + 4'd1;
          ch_start = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_CLEAR: state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!irq) begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // ch_done only fires while the channel is active, i.e. in ADDR or DATA
    if (ch_done) begin
      data_d   = ch_data;
      err_d    = ch_err;
      rindex_d = idx_q;
      last_d   = (idx_q == LAST_IDX);
      valid_d  = 1'b1;
    end
    ch_addr = AW'(BASE_ADDRESS + int'(idx_d) * REG_STRIDE);
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      clear_q  <= 1'b0;
      data_q   <= '0;
      rindex_q <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      frame_q  <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      clear_q  <= clear_d;
      data_q   <= data_d;
      rindex_q <= rindex_d;
      err_q    <= err_d;
      last_q   <= last_d;
      frame_q  <= frame_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule

// File: tb/tb_frequency_report_reader.sv
// Scoreboard bench: stimulus queues expected words and read addresses, a
// negedge monitor pops and compares whenever the DUT hands something over.
module tb_frequency_report_reader;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  i;
    logic        e;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          irq = 1'b0;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic [31:0]   result_data;
  logic [3:0]    result_index;
  logic          result_error, result_last, result_valid;
  logic          result_ready = 1'b1;
  logic          analyzer_clear, busy;
  logic [15:0]   frame_count;
  logic [7:0]    overrun_count;

  int checks = 0, fails = 0, clear_cnt = 0;
  int slv_base = 100;
  logic [AW-1:0] stall_addr = '1, err_addr = '1;
  logic pend;
  bit bp = 1'b0;
  exp_t exp_q[$];
  logic [AW-1:0] addr_q[$];

  always #5 clk = ~clk;

  frequency_report_reader #(.READ_TIMEOUT_CYCLES(16)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n), .irq(irq),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .result_data(result_data), .result_index(result_index), .result_error(result_error),
    .result_last(result_last), .result_valid(result_valid), .result_ready(result_ready),
    .analyzer_clear(analyzer_clear), .busy(busy), .frame_count(frame_count),
    .overrun_count(overrun_count)
  );

  // Slave: register n holds slv_base+n; R returns one cycle after the AR handshake.
  assign arready = !pend && (araddr != stall_addr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
    end else begin
      if (rvalid && rready) begin rvalid <= 1'b0; pend <= 1'b0; end
      if (arvalid && arready) begin
        pend   <= 1'b1;
        rvalid <= 1'b1;
        rdata  <= 32'(slv_base) + 32'(araddr >> 2);
        rresp  <= (araddr == err_addr) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int rcyc = 0;
    forever begin
      @(posedge clk); #2;
      if (bp) begin result_ready = (rcyc % 3 == 0); rcyc++; end
      else result_ready = 1'b1;
    end
  end

  // Monitor
  initial begin
    logic arv_prev = 1'b0, stalled = 1'b0;
    logic [38:0] held = '0, now;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin arv_prev = 1'b0; stalled = 1'b0; continue; end
      now = {result_valid, result_data, result_index, result_error, result_last};
      if (analyzer_clear) clear_cnt++;
      if (arvalid && !arv_prev) chk("ar_while_result_pending", 64'(result_valid), 64'd0);
      if (arvalid && arready) begin
        if (addr_q.size() == 0) chk("araddr_unexpected", 64'd1, 64'd0);
        else chk("araddr", 64'(araddr), 64'(addr_q.pop_front()));
      end
      if (stalled) chk("stall_payload_stable", 64'(now), 64'(held));
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) chk("word_unexpected", 64'd1, 64'd0);
        else begin
          x = exp_q.pop_front();
          chk("word{data,idx,err,last}", 64'({result_data, result_index, result_error, result_last}),
              64'({x.d, x.i, x.e, x.l}));
        end
      end
      stalled  = result_valid && !result_ready;
      held     = now;
      arv_prev = arvalid;
    end
  end

  task automatic push_frame(input int base, input int err_reg, input int tmo_reg);
    exp_t x;
    for (int n = 1; n <= 9; n++) begin
      x.d = (n == tmo_reg) ? 32'd0 : 32'(base + n);
      x.i = 4'(n);
      x.e = (n == err_reg) || (n == tmo_reg);
      x.l = (n == 9);
      exp_q.push_back(x);
      if (n != tmo_reg) addr_q.push_back(AW'(n * 4));
    end
  endtask

  task automatic fire();
    @(posedge clk); #1 irq = 1'b1;
  endtask

  task automatic finish_frame(input string nm, input int c0);
    int n = 0;
    while (clear_cnt == c0 && n < 3000) begin @(posedge clk); #1; n++; end
    if (clear_cnt == c0) chk({nm, "_clear_seen"}, 64'd0, 64'd1);
    irq = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_busy_done"}, 64'(busy), 64'd0);
    chk({nm, "_words_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_clear_pulses"}, 64'(clear_cnt - c0), 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 64'({arvalid, araddr, arprot, rready, result_valid, result_data, result_index,
                 result_error, result_last, analyzer_clear, busy}), 64'd0);
    chk({nm, "_counts"}, 64'({frame_count, overrun_count}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset_state");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame: latency and cycle count
    push_frame(100, 0, 0);
    c0 = clear_cnt;
    fire();
    @(posedge clk); #1;
    chk("start_latency_arvalid", 64'(arvalid), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    n = 0;
    while (!analyzer_clear && n < 100) begin @(posedge clk); #1; n++; end
    chk("frame_cycles_to_clear", 64'(n), 64'd27);
    chk("frame_count_1", 64'(frame_count), 64'd1);
    finish_frame("basic", c0);

    // Backpressure 1-in-3
    bp = 1'b1; slv_base = 200;
    push_frame(200, 0, 0);
    c0 = clear_cnt;
    fire();
    finish_frame("backpressure", c0);
    bp = 1'b0;
    chk("frame_count_2", 64'(frame_count), 64'd2);

    // Slave error on register 5
    slv_base = 300; err_addr = AW'(5 * 4);
    push_frame(300, 5, 0);
    c0 = clear_cnt;
    fire();
    finish_frame("slverr", c0);
    err_addr = '1;

    // Timeout on register 3
    slv_base = 400; stall_addr = AW'(3 * 4);
    push_frame(400, 0, 3);
    c0 = clear_cnt;
    fire();
    n = 0;
    while (!(arvalid && araddr == AW'(12)) && n < 200) begin @(posedge clk); #1; n++; end
    n = 0;
    while (arvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", 64'(n), 64'd16);
    finish_frame("timeout", c0);
    stall_addr = '1;

    // Overrun: second irq edge mid-frame
    slv_base = 500;
    push_frame(500, 0, 0);
    c0 = clear_cnt;
    fire();
    repeat (4) @(posedge clk);
    #1 irq = 1'b0;
    @(posedge clk); #1 irq = 1'b1;
    finish_frame("overrun", c0);
    chk("overrun_count", 64'(overrun_count), 64'd1);
    chk("frame_count_5", 64'(frame_count), 64'd5);

    // Reset during DATA of register 4, then a fresh frame
    slv_base = 600;
    push_frame(600, 0, 0);
    fire();
    n = 0;
    while (!(arvalid && arready && araddr == AW'(16)) && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("in_data_reg4", 64'(rready), 64'd1);
    rst_n = 1'b0; irq = 1'b0;
    #1 chk_zero("reset_midframe");
    exp_q.delete(); addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    slv_base = 700;
    push_frame(700, 0, 0);
    c0 = clear_cnt;
    fire();
    finish_frame("after_reset", c0);
    chk("frame_count_after_reset", 64'(frame_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/frequency_report_reader.md
# frequency_report_reader

Register-side consumer of the `frequency_analyzer_manager` result bank.
- On each rising edge of the manager's `irq`, it acts as an AXI4-Lite read master on the manager's S00_AXI port and fetches the nine frequency registers (1..9).
- It emits each word downstream on a valid/ready result stream, then pulses `analyzer_clear` to re-arm the analyzers.
- It sits between the manager and the DMA or report-packing logic, in the same clock domain as the manager's AXI slave.

## Interface
Parameters:
- `C_M00_AXI_ADDR_WIDTH`, default 10: read address width; must match the manager's slave.
- `C_M00_AXI_DATA_WIDTH`, default 32: data width; only 32 is supported.
- `BASE_ADDRESS`, default 0: byte address of register 0 in the slave.
- `FIRST_REGISTER`, default 1: index of the first result register.
- `REGISTERS_NUMBER`, default 9: number of consecutive registers read per frame.
- `READ_TIMEOUT_CYCLES`, default 256: maximum cycles from ARVALID to R handshake.

Ports (clock and reset first):
- `m00_axi_aclk`  in  1  the single clock.
- `m00_axi_aresetn`  in  1  asynchronous, active-low reset.
- `irq`  in  1  manager write-completed level; the rising edge starts a frame.
- `m00_axi_araddr`  out  C_M00_AXI_ADDR_WIDTH  read address.
- `m00_axi_arprot`  out  3  constant 3'b000.
- `m00_axi_arvalid`  out  1  read address valid.
- `m00_axi_arready`  in  1  read address ready.
- `m00_axi_rdata`  in  32  read data.
- `m00_axi_rresp`  in  2  read response.
- `m00_axi_rvalid`  in  1  read data valid.
- `m00_axi_rready`  out  1  read data ready.
- `result_data`  out  32  fetched register value.
- `result_index`  out  4  register number, in the range 1..9.
- `result_error`  out  1  SLVERR/DECERR or timeout on this word.
- `result_last`  out  1  marks the final word of the frame.
- `result_valid`  out  1  stream valid.
- `result_ready`  in  1  stream ready.
- `analyzer_clear`  out  1  one-cycle pulse to the manager's `clear` input.
- `busy`  out  1  high while a frame is in progress.
- `frame_count`  out  16  completed frames; wraps from 0xFFFF to 0.
- `overrun_count`  out  8  irq edges dropped while busy; saturates at 255.

## Operation
- Reset (asynchronous, immediate): every output is 0, the FSM is IDLE, and `irq_q` is 0. This applies mid-transaction too. The bench guarantees the slave is reset together with this block.
- Edge detect: `irq_q` registers `irq` every cycle. A start condition is `irq & ~irq_q`.
- FSM states: IDLE, ADDR, DATA, PUSH, CLEAR, WAIT_LOW.
- IDLE: on a start condition, set `idx` = FIRST_REGISTER and `busy` = 1, then go to ADDR.
- ADDR: `arvalid` = 1 and `araddr` = BASE_ADDRESS + idx*4. On `arvalid & arready`, go to DATA.
- DATA: `rready` = 1. On `rvalid & rready`:
  - capture `rdata`;
  - set `err` = (rresp != 0);
  - go to PUSH.
- Timeout: the counter clears on entering ADDR and counts in ADDR and DATA. When it reaches READ_TIMEOUT_CYCLES-1:
  - `result_data` = 0 and `err` = 1;
  - go to PUSH;
  - `arvalid` and `rready` drop.
  - A late R beat after a timeout is not tracked. Recovery from that case requires reset.
- PUSH: `result_valid` = 1, with data, index, error and last held stable until `result_ready`. On handshake:
  - if idx == FIRST_REGISTER+REGISTERS_NUMBER-1, go to CLEAR;
  - otherwise idx++ and go to ADDR.
- CLEAR: `analyzer_clear` = 1 for exactly one cycle; `frame_count`++. Then go to WAIT_LOW.
- WAIT_LOW: stay until `irq` = 0, then `busy` = 0 and go to IDLE.
- Overrun: a start condition seen in any state other than IDLE increments `overrun_count`, saturating. The current frame is not disturbed.
- Error handling: an error word is still delivered, and the frame continues with the next register.

## Timing
- Start latency: if the irq edge is sampled at cycle T, `arvalid` is high at T+1.
- With `arready` = 1 and `rvalid` returned one cycle after the AR handshake, each word costs 3 cycles plus stream backpressure. A full frame with `result_ready` tied high takes 27 cycles plus the CLEAR cycle.
- AR handshake rules:
  - at most one outstanding read;
  - `arvalid` never drops before `arready` (timeout excepted);
  - `araddr` is stable while `arvalid` is high.
- `result_valid` rises the cycle after the R handshake. The stream obeys valid/ready rules: no retraction, and payload stable while stalled.
- `analyzer_clear` follows the last stream handshake by 1 cycle.
- All outputs are registered.

## Structure
- A shared package (`frequency_analyzer_defs`) holds:
  - the register indices (first frequency register 1, count 9; configuration registers 10..17);
  - the RESP encodings OKAY=0 and SLVERR=2;
  - the byte stride of 4.
- The manager and this block both use this package.
- One sub-module, `axi_lite_read_channel`, performs a single AR/R transaction with timeout and reports data and error. The frame FSM lives in the top module.

## Test plan
- Basic frame: with `result_ready` = 1, drive an irq rising edge; the slave returns value 100+n for register n. Required: the 9 words 101..109 with indices 1..9, araddr 0x004..0x024, `result_last` only on index 9, one `analyzer_clear` pulse, and `frame_count` = 1.
- Backpressure: toggle `result_ready` on a 1-in-3 pattern. Required: words stay stable while stalled, with no loss, duplication or reordering, and the next ARVALID only after each handshake.
- Slave error: register 5 returns rresp = 2. Required: that word has `result_error` = 1, the other eight have 0, and the frame completes.
- Timeout: `arready` stuck at 0 for register 3 with READ_TIMEOUT_CYCLES = 16. Required: after 16 cycles, a word with index 3, data 0 and error 1; the frame continues with register 4.
- Overrun: a second irq edge mid-frame (irq pulsed low then high). Required: `overrun_count` = 1, the frame is unaffected, and only one clear pulse.
- Reset mid-frame: assert `m00_axi_aresetn` low during DATA of register 4. Required: all outputs are 0 immediately. After release plus a new irq edge, a fresh frame starts at register 1.
